// File: rtl/wisc_pipe_pkg.sv
// Shared types and sizing for the pipeline control unit: FSM state encoding,
// the control-wait timeout limit and the counter widths.
package wisc_pipe_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DATA_STALL = 2'd1,
    CTRL_WAIT  = 2'd2,
    HALT       = 2'd3
  } state_t;

  localparam int              WAIT_W        = 8;
  localparam logic [WAIT_W-1:0] CTRL_WAIT_MAX = 8'd255;
  localparam int              PERF_W        = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline hazard/control-flow sequencer: stalls, flushes, call/ret wait with
// timeout, and halt. Optional perf counters under `PIPE_CTRL_PERF_EN`.
//
// state      | meaning
// RUN        | normal issue, evaluates branch/hlt/hazard/call/ret
// DATA_STALL | holding PC and IF/ID while the data hazard persists
// CTRL_WAIT  | call/ret in flight, IF/ID flushed until the PC target lands
// HALT       | core stopped, only reset leaves this state
module pipe_ctrl_unit
  import wisc_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hazard,
  input  logic       call,
  input  logic       ret,
  input  logic       PC_update,
  input  logic       branch_taken,
  input  logic       hlt,
  output logic       PC_we,
  output logic       IF_ID_we,
  output logic       IF_ID_flush,
  output logic       ID_EX_bubble,
  output logic       halted,
  output logic       ctrl_timeout,
  output logic [1:0] state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
`endif
);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt, wait_d, wait_inc;
  logic              timeout_q, timeout_set;

  assign wait_inc = wait_cnt + WAIT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
      if (timeout_set) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    timeout_set  = 1'b0;
    PC_we        = 1'b1;
    IF_ID_we     = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;

    // A taken branch overrides everything except HALT.
    if ((state_q != HALT) && branch_taken) begin
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
      state_d      = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (hlt) begin
            PC_we    = 1'b0;
            IF_ID_we = 1'b0;
            state_d  = HALT;
          end else if (hazard) begin
            PC_we        = 1'b0;
            IF_ID_we     = 1'b0;
            ID_EX_bubble = 1'b1;
            state_d      = DATA_STALL;
          end else if (call || ret) begin
            state_d = CTRL_WAIT;
          end
        end
        DATA_STALL: begin
          if (hazard) begin
            PC_we        = 1'b0;
            IF_ID_we     = 1'b0;
            ID_EX_bubble = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        CTRL_WAIT: begin
          IF_ID_flush = 1'b1;
          if (PC_update) begin
            state_d = RUN;
          end else begin
            PC_we = 1'b0;
            if (wait_inc == CTRL_WAIT_MAX) begin
              timeout_set = 1'b1;
              state_d     = HALT;
            end else begin
              wait_d = wait_inc;
            end
          end
        end
        default: begin
          PC_we        = 1'b0;
          IF_ID_we     = 1'b0;
          ID_EX_bubble = 1'b1;
        end
      endcase
    end

    // Keep the pipeline frozen and drained while reset is asserted.
    if (!rst_n) begin
      PC_we        = 1'b0;
      IF_ID_we     = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end
  end

  assign state        = state_q;
  assign halted       = (state_q == HALT);
  assign ctrl_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state_q == DATA_STALL) || (state_q == CTRL_WAIT)),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state_q != HALT) && branch_taken),
    .count (flush_count)
  );
`endif

endmodule
